// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the max-pool/ReLU layer: FSM states, the IEEE-754
// total-order key and the zero constant.
package maxpool_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // Maps a float's bit pattern to an unsigned key whose order matches numeric order,
  // with -0 below +0.
  function automatic logic [31:0] fp_key(input logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

endpackage

// File: rtl/maxpool_relu_layer_if.sv
// Feature-map handshake bundle between the convolution layer, this layer and the next one.
interface maxpool_relu_layer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int H          = 28,
  parameter int W          = 28
);
  logic [0:H*W*DATA_WIDTH-1]             conv_out;
  logic                                  pool_ena;
  logic [0:(H/2)*(W/2)*DATA_WIDTH-1]     pool_out;
  logic                                  pool_busy;
  logic                                  pool_done;

  modport master (output conv_out, output pool_ena,
                  input  pool_out, input  pool_busy, input pool_done);
  modport slave  (input  conv_out, input  pool_ena,
                  output pool_out, output pool_busy, output pool_done);
endinterface

// File: rtl/maxpool_relu_layer_pool_max4.sv
// Combinational 4-input max of float bit patterns. MAXPOOL_RELU_EN: clamp negatives to +0
// and compare unsigned; otherwise compare by total-order key and pass the winner unchanged.
module pool_max4
  import maxpool_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] c,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] m
);

`ifdef MAXPOOL_RELU_EN
  function automatic logic [DATA_WIDTH-1:0] prep(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? FP_ZERO : x;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] x,
                                                 input logic [DATA_WIDTH-1:0] y);
    return (x > y) ? x : y;
  endfunction
`else
  function automatic logic [DATA_WIDTH-1:0] prep(input logic [DATA_WIDTH-1:0] x);
    return x;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] x,
                                                 input logic [DATA_WIDTH-1:0] y);
    return (fp_key(x) >= fp_key(y)) ? x : y;
  endfunction
`endif

  always_comb begin
    m = max2(max2(prep(a), prep(b)), max2(prep(c), prep(d)));
  end

endmodule

// File: rtl/maxpool_relu_layer.sv
// 2x2 stride-2 max pooling (optional ReLU via MAXPOOL_RELU_EN) over a flat HxW float map,
// one pooled pixel per clock, with the ena/busy/done handshake of the conv layer.
module maxpool_relu_layer
  import maxpool_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int H          = 28,
  parameter int W          = 28
) (
  input logic            clk,
  input logic            reset,
  maxpool_relu_layer_if.slave bus
);

  localparam int OH = H / 2;
  localparam int OW = W / 2;
  localparam int RW = (OH > 1) ? $clog2(OH) : 1;
  localparam int CW = (OW > 1) ? $clog2(OW) : 1;
  localparam int unsigned WU  = W;
  localparam int unsigned OWU = OW;
  localparam int unsigned DWU = DATA_WIDTH;

  state_t          state, state_nx;
  logic [RW-1:0]   r;
  logic [CW-1:0]   c;
  logic            last;
  int unsigned     base;
  int unsigned     slot;
  logic [DATA_WIDTH-1:0] w0, w1, w2, w3, mx;

  // Window top-left element (2r,2c); the other three sit one column / one row further.
  always_comb begin
    base = (2 * 32'(r) * WU + 2 * 32'(c)) * DWU;
    slot = 32'(r) * OWU + 32'(c);
    w0   = bus.conv_out[base +: DATA_WIDTH];
    w1   = bus.conv_out[base + DWU +: DATA_WIDTH];
    w2   = bus.conv_out[base + WU * DWU +: DATA_WIDTH];
    w3   = bus.conv_out[base + (WU + 1) * DWU +: DATA_WIDTH];
  end

  pool_max4 #(.DATA_WIDTH(DATA_WIDTH)) u_max (
    .a (w0),
    .b (w1),
    .c (w2),
    .d (w3),
    .m (mx)
  );

  assign last = (r == RW'(OH - 1)) && (c == CW'(OW - 1));

  always_comb begin
    state_nx      = state;
    bus.pool_busy = 1'b0;
    bus.pool_done = 1'b0;
    case (state)
      IDLE: if (bus.pool_ena) state_nx = RUN;
      RUN: begin
        bus.pool_busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        bus.pool_done = 1'b1;
        if (!bus.pool_ena) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      r            <= '0;
      c            <= '0;
      bus.pool_out <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.pool_ena) begin
        r <= '0;
        c <= '0;
      end else if (state == RUN) begin
        bus.pool_out[slot * DWU +: DATA_WIDTH] <= mx;
        if (c == CW'(OW - 1)) begin
          c <= '0;
          r <= r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_relu_layer.sv
// Bench for maxpool_relu_layer: a 4x4 instance for directed windows and a default 28x28
// instance for handshake, raster order and mid-run reset, against a value-based float model.
module tb_maxpool_relu_layer;

  logic clk;
  logic reset;
  int   cmp;
  int   err;

  logic [31:0] mapv    [784];
  logic [31:0] ref_out [196];
  logic [31:0] prev_ref[196];

`ifdef MAXPOOL_RELU_EN
  localparam logic [31:0] EXP_NEG    = 32'h0000_0000;
  localparam logic [31:0] EXP_SIGNED = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_NEG    = 32'h8000_0000;
  localparam logic [31:0] EXP_SIGNED = 32'hBF00_0000;
`endif

  maxpool_relu_layer_if #(.DATA_WIDTH(32), .H(4), .W(4)) bus_s ();
  maxpool_relu_layer_if #(.DATA_WIDTH(32), .H(28), .W(28)) bus_b ();

  maxpool_relu_layer #(.DATA_WIDTH(32), .H(4), .W(4)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  maxpool_relu_layer #(.DATA_WIDTH(32), .H(28), .W(28)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp)
    else begin
      err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Numeric value of a finite IEEE-754 single from its fields.
  function automatic real fval(input logic [31:0] x);
    int  e;
    int  m;
    real mag;
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    if (e != 0) m += (1 << 23);
    mag = real'(m) * (2.0 ** ((e == 0 ? 1 : e) - 150));
    return x[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef MAXPOOL_RELU_EN
    return x[31] ? 32'h0 : x;
`else
    return x;
`endif
  endfunction

  function automatic bit greater(input logic [31:0] x, input logic [31:0] y);
    real rx, ry;
    rx = fval(x);
    ry = fval(y);
    if (rx != ry) return rx > ry;
    return !x[31] && y[31];
  endfunction

  function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    logic [31:0] v[4];
    logic [31:0] best;
    v[0] = relu(a); v[1] = relu(b); v[2] = relu(c); v[3] = relu(d);
    best = v[0];
    for (int k = 1; k < 4; k++) if (greater(v[k], best)) best = v[k];
    return best;
  endfunction

  function automatic logic [31:0] rnd_float();
    logic s;
    s = 1'($urandom);
    if ($urandom_range(0, 15) == 0) return {s, 31'h0};
    return {s, 8'($urandom_range(0, 254)), 23'($urandom)};
  endfunction

  task automatic compute_ref(input int w);
    int ow, idx;
    ow = w / 2;
    for (int r = 0; r < ow; r++)
      for (int c = 0; c < ow; c++) begin
        idx = 2 * r * w + 2 * c;
        ref_out[r * ow + c] = ref_max(mapv[idx], mapv[idx + 1], mapv[idx + w], mapv[idx + w + 1]);
      end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) mapv[i] = rnd_float();
  endtask

  task automatic load_small();
    for (int i = 0; i < 16; i++) bus_s.conv_out[i*32 +: 32] = mapv[i];
  endtask

  task automatic load_big();
    for (int i = 0; i < 784; i++) bus_b.conv_out[i*32 +: 32] = mapv[i];
  endtask

  task automatic run_small(input string tag, input bit chk0, input logic [31:0] exp0);
    int cnt;
    load_small();
    compute_ref(4);
    bus_s.pool_ena = 1'b1;
    step();
    cnt = 0;
    while (bus_s.pool_busy === 1'b1 && cnt < 50) begin
      cnt++;
      step();
    end
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'd4);
    chk({tag, "_done"}, 32'(bus_s.pool_done), 32'd1);
    for (int k = 0; k < 4; k++) chk({tag, "_slot"}, bus_s.pool_out[k*32 +: 32], ref_out[k]);
    if (chk0) chk({tag, "_slot0_const"}, bus_s.pool_out[0 +: 32], exp0);
    bus_s.pool_ena = 1'b0;
    step();
    chk({tag, "_done_drop"}, 32'(bus_s.pool_done), 32'd0);
  endtask

  task automatic run_big(input string tag, input bit toggle);
    int cnt;
    load_big();
    compute_ref(28);
    bus_b.pool_ena = 1'b1;
    step();
    cnt = 0;
    while (bus_b.pool_busy === 1'b1 && cnt < 400) begin
      cnt++;
      if (toggle) bus_b.pool_ena = 1'($urandom);
      step();
    end
    bus_b.pool_ena = 1'b1;
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'd196);
    chk({tag, "_done"}, 32'(bus_b.pool_done), 32'd1);
    for (int k = 0; k < 196; k++) chk({tag, "_slot"}, bus_b.pool_out[k*32 +: 32], ref_out[k]);
  endtask

  task automatic chk_cleared(input string tag);
    int nz;
    nz = 0;
    for (int k = 0; k < 196; k++) if (bus_b.pool_out[k*32 +: 32] !== 32'h0) nz++;
    chk({tag, "_big_nonzero_slots"}, 32'(nz), 32'd0);
    chk({tag, "_big_busy"}, 32'(bus_b.pool_busy), 32'd0);
    chk({tag, "_big_done"}, 32'(bus_b.pool_done), 32'd0);
  endtask

  initial begin
    int cnt;
    cmp = 0;
    err = 0;

    // Reset held with random input and a pending request.
    reset = 1'b0;
    fill_random(784);
    load_big();
    load_small();
    bus_s.pool_ena = 1'b1;
    bus_b.pool_ena = 1'b1;
    step(); step(); step();
    chk_cleared("rst");
    chk("rst_small_slot0", bus_s.pool_out[0 +: 32], 32'h0);
    chk("rst_small_busy", 32'(bus_s.pool_busy), 32'd0);
    chk("rst_small_done", 32'(bus_s.pool_done), 32'd0);
    reset = 1'b1;
    step();
    chk("rst_release_big_busy", 32'(bus_b.pool_busy), 32'd1);
    chk("rst_release_small_busy", 32'(bus_s.pool_busy), 32'd1);
    cnt = 0;
    while (bus_b.pool_done !== 1'b1 && cnt < 400) begin
      cnt++;
      step();
    end
    chk("rst_release_big_done", 32'(bus_b.pool_done), 32'd1);
    chk("rst_release_small_done", 32'(bus_s.pool_done), 32'd1);
    bus_s.pool_ena = 1'b0;
    bus_b.pool_ena = 1'b0;
    step();

    // Directed 4x4 windows at (0,0); everything else zero.
    for (int i = 0; i < 16; i++) mapv[i] = 32'h0;
    mapv[0] = 32'h3F80_0000; mapv[1] = 32'h4000_0000;
    mapv[4] = 32'h3F00_0000; mapv[5] = 32'hC040_0000;
    run_small("basic", 1'b1, 32'h4000_0000);
    mapv[0] = 32'hBF80_0000; mapv[1] = 32'hC000_0000;
    mapv[4] = 32'h8000_0000; mapv[5] = 32'hC040_0000;
    run_small("neg", 1'b1, EXP_NEG);
    mapv[0] = 32'hC040_0000; mapv[1] = 32'hBF80_0000;
    mapv[4] = 32'hC000_0000; mapv[5] = 32'hBF00_0000;
    run_small("signed", 1'b1, EXP_SIGNED);
    mapv[0] = 32'h3F80_0000; mapv[1] = 32'h7FC0_0000;
    mapv[4] = 32'hBF80_0000; mapv[5] = 32'h0000_0000;
    run_small("pos_nan", 1'b1, 32'h7FC0_0000);
    for (int t = 0; t < 6; t++) begin
      fill_random(16);
      run_small("rand4", 1'b0, 32'h0);
    end

    // 28x28: ena toggling during RUN, then hold and drop.
    fill_random(784);
    run_big("toggle", 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_done", 32'(bus_b.pool_done), 32'd1);
    end
    bus_b.pool_ena = 1'b0;
    step();
    chk("drop_done", 32'(bus_b.pool_done), 32'd0);
    chk("drop_busy", 32'(bus_b.pool_busy), 32'd0);

    // New run overwrites slots one per edge in raster order.
    for (int k = 0; k < 196; k++) prev_ref[k] = ref_out[k];
    fill_random(784);
    load_big();
    compute_ref(28);
    bus_b.pool_ena = 1'b1;
    step();
    for (int k = 0; k < 196; k++) begin
      step();
      chk("raster_new", bus_b.pool_out[k*32 +: 32], ref_out[k]);
      if (k < 195) chk("raster_old", bus_b.pool_out[(k+1)*32 +: 32], prev_ref[k+1]);
    end
    chk("raster_done", 32'(bus_b.pool_done), 32'd1);
    bus_b.pool_ena = 1'b0;
    step();

    // Reset 50 cycles into a run, then a full clean run.
    fill_random(784);
    load_big();
    bus_b.pool_ena = 1'b1;
    step();
    for (int i = 0; i < 50; i++) step();
    #1 reset = 1'b0;
    #1;
    chk_cleared("midrst");
    reset = 1'b1;
    fill_random(784);
    run_big("after_rst", 1'b0);
    bus_b.pool_ena = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule

// File: doc/maxpool_relu_layer.md
Name: maxpool_relu_layer

Overview:
- Downstream stage of the single-channel convolution layer.
- Consumes the flat H×W feature map of IEEE-754 single-precision values that the convolution layer produces.
- Applies optional ReLU, then 2×2 stride-2 max pooling, one output pixel per clock.
- Presents the (H/2)×(W/2) pooled map to the next layer, using the same ena/done handshake style as the convolution layer.

Parameters:
- DATA_WIDTH, 32, bits per element (IEEE-754 single).
- H, 28, input map height; must be even.
- W, 28, input map width; must be even.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- conv_out  in  [0:H*W*DATA_WIDTH-1]  input map. Pixel (i,j) is at [(i*W+j)*DATA_WIDTH +: DATA_WIDTH]. Upstream holds it stable from pool_ena assertion until pool_done.
- pool_ena  in  1  start request, level; upstream drives it from its conv_done.
- pool_out  out  [0:(H/2)*(W/2)*DATA_WIDTH-1]  pooled map. Pixel (r,c) is at [(r*(W/2)+c)*DATA_WIDTH +: DATA_WIDTH]; registered.
- pool_busy  out  1  high while in RUN.
- pool_done  out  1  high in DONE.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, r=c=0.
  - pool_out=0, pool_busy=0, pool_done=0.
  - Reset mid-RUN aborts the run and clears all partial results.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - pool_ena==1 at a clock edge → RUN, r=0, c=0, pool_busy=1.
  - pool_out keeps its previous contents.
- RUN, each edge:
  - Computes m = max of window elements (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
  - Writes m to pool_out slot (r,c).
  - Advances the counters: c==W/2-1 → c=0, r=r+1; otherwise c=c+1.
  - The edge that writes slot (H/2-1, W/2-1) → DONE, pool_busy=0, pool_done=1.
- pool_ena changes during RUN are ignored; RUN always completes.
- DONE:
  - pool_done stays 1 while pool_ena==1.
  - pool_ena==0 → IDLE, pool_done=0. Requires a full handshake before a new start.
- Latency: pool_ena sampled at edge 0 → slots written at edges 1..N, N=(H/2)*(W/2) (196 by default) → pool_done visible after edge N.
- Max operation:
  - Pure combinational tree of three 2-input comparators; no floating-point unit.
  - With ReLU enabled:
    - Each element with sign bit 1 (including -0 and negative NaNs) becomes 32'h00000000 before comparison.
    - All remaining values are non-negative, so the compare is an unsigned integer compare of the bit patterns.
    - Positive NaN beats any number.
  - Ties: any tied element may be selected; the results are bit-identical.
- Counters: r and c are sized $clog2(H/2) and $clog2(W/2), minimum 1 bit.

Optional Feature:
- Macro: MAXPOOL_RELU_EN.
- Defined:
  - ReLU is applied before pooling, as above.
  - Comparators use unsigned integer compare.
- Undefined:
  - No ReLU; raw values are pooled.
  - Comparators use the total-order key: sign 0 → {1'b1, x[30:0]}; sign 1 → ~x.
  - The larger key wins, so -0 < +0 and negative values are ordered correctly.
  - The winning element's original bits are output unchanged.

Decomposition:
- Shared package maxpool_pkg:
  - State encoding localparams (IDLE/RUN/DONE).
  - Function fp_key(x) implementing the total-order key.
  - Constant FP_ZERO = 32'h00000000.
- One sub-module, pool_max4: combinational 4-input max of DATA_WIDTH values, including the ReLU / key logic under the macro.
- maxpool_relu_layer contains the FSM, counters, window slicing and pool_out write.

Test Plan:
- Reset: hold reset=0 with random conv_out and pool_ena=1 → pool_out==0, pool_busy==0, pool_done==0; after release, the run starts on the next edge.
- Basic pooling, H=W=4, MAXPOOL_RELU_EN defined:
  - Stimulus: window (0,0) = {1.0=3F800000, 2.0=40000000, 0.5=3F000000, -3.0=C0400000}; all other elements 0.
  - Required: slot 0 = 40000000, other slots 0.
  - Required: pool_done rises after edge 4 (N=4), with pool_busy high for exactly 4 cycles.
- ReLU clamp: window all negative {BF800000, C0000000, 80000000, C0400000} → output 00000000 (ReLU on). Without the macro, the same window → 80000000 (-0 is the largest).
- Signed order, macro undefined: window {C0400000, BF800000, C0000000, BF000000} → output BF000000 (-0.5).
- Handshake, default 28×28:
  - Toggle pool_ena during RUN → no effect; done after exactly 196 edges.
  - Hold pool_ena → pool_done stays 1; drop pool_ena → IDLE next edge.
  - Re-assert pool_ena → new run overwrites slots in raster order.
- Reset mid-run: assert reset at cycle 50 of RUN → outputs clear immediately; after release with pool_ena=1 the full 196-cycle run completes with correct results against the golden model.
